// File: rtl/vball_rom_arbiter.sv
// Shared external ROM arbiter for the BG tile fetcher and the PCM line fetcher.
// One external access is outstanding at a time. BG requests win over PCM
// requests, but only for BG_RUN_MAX grants in a row while a PCM line waits.
// PCM bytes fill an 8-byte line buffer that is tagged with the line address.
module vball_rom_arbiter #(
  parameter logic [24:0] BG_BASE    = 25'h100000,
  parameter logic [24:0] PCM_BASE   = 25'h180000,
  parameter int          BG_RUN_MAX = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        bg_read,
  input  logic [18:0] bg_addr,
  output logic [7:0]  bg_data,
  output logic        bg_rdy,
  input  logic        pcm_rom_read,
  input  logic [17:0] pcm_rom_addr,
  output logic [7:0]  pcm_rom_data,
  output logic        pcm_rom_data_rdy,
  output logic        mem_req,
  output logic [24:0] mem_addr,
  input  logic [7:0]  mem_data,
  input  logic        mem_ack,
  output logic [1:0]  fsm_state
);

  // External handshake: mem_req rises with a registered mem_addr and both
  // hold until the cycle mem_ack=1 is sampled; mem_req drops on the next
  // cycle. mem_ack seen in any other state is ignored.

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BG_WAIT  = 2'd1,
    PCM_WAIT = 2'd2
  } state_t;

  localparam int RUN_W = (BG_RUN_MAX < 1) ? 1 : $clog2(BG_RUN_MAX + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(BG_RUN_MAX);

  state_t           state;
  logic             bg_pend;
  logic [18:0]      bg_addr_q;
  logic             pcm_pend;
  logic [14:0]      tag;
  logic [2:0]       cnt;
  logic             line_valid;
  logic             stale;
  logic [RUN_W-1:0] bg_run;
  logic [7:0]       buffer [8];

  logic        grant_bg;
  logic        grant_pcm;
  logic        pcm_keep;
  logic [24:0] bg_sum;
  logic [24:0] pcm_sum;

  // Grant decision, byte-accept qualifier and external address sums
  always_comb begin
    grant_bg  = (state == IDLE) && bg_pend && (!pcm_pend || (bg_run < RUN_MAX));
    grant_pcm = (state == IDLE) && !grant_bg && pcm_pend;
    pcm_keep  = (state == PCM_WAIT) && mem_ack && !stale && !pcm_rom_read;
    bg_sum    = BG_BASE + {6'd0, bg_addr_q};
    pcm_sum   = PCM_BASE + {7'd0, tag, cnt};
  end

  // Arbiter FSM, request latches and line bookkeeping
  always_ff @(posedge clk_sys) begin
    if (!reset) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      bg_data    <= '0;
      bg_rdy     <= 1'b0;
      bg_pend    <= 1'b0;
      bg_addr_q  <= '0;
      pcm_pend   <= 1'b0;
      line_valid <= 1'b0;
      cnt        <= '0;
      bg_run     <= '0;
      tag        <= '0;
      stale      <= 1'b0;
    end else begin
      bg_rdy <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_bg) begin
            mem_req  <= 1'b1;
            mem_addr <= bg_sum;
            bg_pend  <= 1'b0;
            if (bg_run != RUN_MAX) bg_run <= bg_run + 1'b1;
            state    <= BG_WAIT;
          end else if (grant_pcm) begin
            mem_req  <= 1'b1;
            mem_addr <= pcm_sum;
            bg_run   <= '0;
            state    <= PCM_WAIT;
          end
        end
        BG_WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            bg_data <= mem_data;
            bg_rdy  <= 1'b1;
            state   <= IDLE;
          end
        end
        PCM_WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            stale   <= 1'b0;
            state   <= IDLE;
            if (pcm_keep) begin
              cnt <= cnt + 3'd1;
              if (cnt == 3'd7) begin
                pcm_pend   <= 1'b0;
                line_valid <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase

      // The BG run only matters while a PCM line is waiting.
      if (!pcm_pend) bg_run <= '0;

      // A new BG request always replaces the latched one.
      if (bg_read) begin
        bg_pend   <= 1'b1;
        bg_addr_q <= bg_addr;
      end

      // A new PCM line restarts the fill; a byte already in flight (or being
      // granted right now) belongs to the old line and must be dropped.
      if (pcm_rom_read) begin
        tag        <= pcm_rom_addr[17:3];
        line_valid <= 1'b0;
        cnt        <= 3'd0;
        pcm_pend   <= 1'b1;
        if (((state == PCM_WAIT) && !mem_ack) || grant_pcm) stale <= 1'b1;
      end
    end
  end

  // Line buffer storage; contents are meaningless until line_valid is set
  always_ff @(posedge clk_sys) begin
    if (pcm_keep) buffer[cnt] <= mem_data;
  end

  assign pcm_rom_data     = buffer[pcm_rom_addr[2:0]];
  assign pcm_rom_data_rdy = line_valid && (tag == pcm_rom_addr[17:3]);
  assign fsm_state        = state;

endmodule

// File: doc/vball_rom_arbiter.md
VBALL_ROM_ARBITER -- requirements
Module: vball_rom_arbiter

Interface
REQ-001 Parameter BG_BASE, default 25'h100000: external byte offset of the BG tile gfx region.
REQ-002 Parameter PCM_BASE, default 25'h180000: external byte offset of the PCM sample region.
REQ-003 Parameter BG_RUN_MAX, default 4: maximum consecutive BG grants while a PCM fetch waits.
REQ-004 clk_sys  in  1  system clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 bg_read  in  1  one-cycle request pulse from the BG renderer.
REQ-007 bg_addr  in  19  BG byte address, sampled when bg_read=1.
REQ-008 bg_data  out  8  last BG byte returned.
REQ-009 bg_rdy  out  1  one-cycle pulse; bg_data valid.
REQ-010 pcm_rom_read  in  1  one-cycle request pulse from the PCM engine on an 8-byte line change.
REQ-011 pcm_rom_addr  in  18  current PCM byte address; held stable by the PCM engine between requests.
REQ-012 pcm_rom_data  out  8  line-buffer byte selected by pcm_rom_addr[2:0].
REQ-013 pcm_rom_data_rdy  out  1  level; the line buffer is full and its tag equals pcm_rom_addr[17:3].
REQ-014 mem_req  out  1  external read request; held high until mem_ack.
REQ-015 mem_addr  out  25  external byte address; stable while mem_req=1.
REQ-016 mem_data  in  8  external read data; valid when mem_ack=1.
REQ-017 mem_ack  in  1  one-cycle acknowledge.

Function
REQ-018 The arbiter SHALL be an FSM with states IDLE, BG_WAIT and PCM_WAIT, and SHALL keep at most one external access outstanding.
REQ-019 On bg_read, the arbiter SHALL set bg_pend and latch bg_addr; a new bg_read while bg_pend=1 SHALL overwrite the latched address (latest wins).
REQ-020 On pcm_rom_read, the arbiter SHALL latch the tag pcm_rom_addr[17:3], clear line_valid, set byte counter cnt=0 and set pcm_pend.
REQ-021 In IDLE, if bg_pend=1 and (pcm_pend=0 or bg_run<BG_RUN_MAX), the FSM SHALL issue mem_req with mem_addr=BG_BASE+bg_addr_latched, clear bg_pend, increment bg_run (saturating), and move to BG_WAIT.
REQ-022 In IDLE otherwise, if pcm_pend=1, the FSM SHALL issue mem_req with mem_addr=PCM_BASE+{tag,cnt}, clear bg_run, and move to PCM_WAIT.
REQ-023 bg_run SHALL also clear whenever pcm_pend=0.
REQ-024 mem_req SHALL rise on the cycle after the grant decision and SHALL stay high with mem_addr constant until the mem_ack cycle.
REQ-025 mem_req SHALL drop in the cycle after mem_ack, and the FSM SHALL return to IDLE; the earliest next grant is the following cycle.
REQ-026 On mem_ack in BG_WAIT, the arbiter SHALL register mem_data into bg_data and pulse bg_rdy in the next cycle.
REQ-027 On mem_ack in PCM_WAIT with no intervening pcm_rom_read, the arbiter SHALL write mem_data to buffer[cnt] and increment cnt.
REQ-028 When cnt wraps from 7 to 0, the arbiter SHALL clear pcm_pend and set line_valid.
REQ-029 A pcm_rom_read arriving during PCM_WAIT SHALL mark the in-flight byte stale: its mem_ack SHALL be consumed, the byte discarded, and the new line fetched from cnt=0.
REQ-030 BG SHALL be able to preempt a PCM line between bytes; a partially filled line SHALL resume at its current cnt.
REQ-031 pcm_rom_data SHALL be combinational from buffer[pcm_rom_addr[2:0]].
REQ-032 pcm_rom_data_rdy SHALL be combinational: line_valid & (tag==pcm_rom_addr[17:3]).
REQ-033 If bg_read and pcm_rom_read arrive in the same cycle, both SHALL be latched, and BG SHALL be granted first.
REQ-034 mem_ack outside BG_WAIT and PCM_WAIT SHALL be ignored.
REQ-035 Address sums SHALL be 25-bit with carry discarded.

Reset
REQ-036 While reset=0 at a clock edge, the arbiter SHALL set: state IDLE; mem_req 0; mem_addr 0; bg_data 0; bg_rdy 0; bg_pend 0; pcm_pend 0; line_valid 0; cnt 0; bg_run 0; tag 0; buffer contents don't-care.
REQ-037 Reset asserted mid-access SHALL abandon the access, and the first mem_ack after reset release SHALL be ignored per REQ-034.

Verification
REQ-038 Scenario: bg_read, bg_addr=19'h00010; mem_ack with data 8'hA5 after 3 cycles -> mem_addr=25'h100010, then bg_rdy one cycle with bg_data=8'hA5.
REQ-039 Scenario: pcm_rom_read, pcm_rom_addr=18'h00108; 8 acks with data 0..7 -> mem_addr sequence 25'h180108..25'h18010F, then pcm_rom_data_rdy=1, and pcm_rom_addr=18'h0010B yields data 3.
REQ-040 Scenario: bg_read and pcm_rom_read in the same cycle -> BG granted first, PCM byte 0 fetched next.
REQ-041 Scenario: continuous bg_read with a PCM line pending -> exactly 4 BG grants, then 1 PCM grant, repeating.
REQ-042 Scenario: pcm_rom_read to 18'h00200 during PCM_WAIT at cnt=5 -> the acked byte is discarded, the refetch starts at 25'h180200, and rdy stays 0 until 8 new bytes arrive.
REQ-043 Scenario: reset=0 during BG_WAIT, released, then a stray mem_ack -> no bg_rdy, mem_req stays 0.
